// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC/instruction-memory stage and decode.
// Buffers up to DEPTH {pc, inst} pairs and presents the oldest to decode show-ahead.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce_i,
  input  logic [AW-1:0]            pc_i,
  input  logic [DW-1:0]            inst_i,
  input  logic                     flush_i,
  input  logic                     id_ready_i,
  output logic                     full_o,
  output logic                     id_valid_o,
  output logic [AW-1:0]            id_pc_o,
  output logic [DW-1:0]            id_inst_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          push;
  logic          pop;

  // Status decodes come only from the registered count, never from the inputs.
  assign full_o     = (cnt == CNT_FULL);
  assign id_valid_o = (cnt != '0);
  assign count_o    = cnt;

  assign push = ce_i & ~full_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;

  assign id_pc_o   = id_valid_o ? pc_mem[rp]   : '0;
  assign id_inst_o = id_valid_o ? inst_mem[rp] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_o <= 1'b0;
    end else if (flush_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      // A fetch presented while full means the PC stage failed to stall.
      if (ce_i && full_o) ovf_o <= 1'b1;
    end
  end

  // NOTE: the entry storage has no reset; an entry is only visible once the
  // occupancy count covers it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp]   <= pc_i;
      inst_mem[wp] <= inst_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based scoreboard model checked
// every cycle, a fill/drain vector table, and hand-written corner sequences.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic        flush_i = 1'b0;
  logic        id_ready_i = 1'b0;
  logic        full_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;
  logic        ovf_o;

  fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .pc_i       (pc_i),
    .inst_i     (inst_i),
    .flush_i    (flush_i),
    .id_ready_i (id_ready_i),
    .full_o     (full_o),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .count_o    (count_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        flush;
    logic        ready;
    logic [2:0]  cnt;
    logic        valid;
    logic        full;
    logic [31:0] hpc;
    logic [31:0] hinst;
  } vec_t;

  entry_t sb[$];
  logic   m_ovf = 1'b0;
  int     total = 0;
  int     bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the popped head, advance, update model, compare.
  task automatic step(input logic r, input logic c, input logic [31:0] p,
                      input logic [31:0] i, input logic f, input logic rd);
    bit     full;
    bit     push;
    bit     pop;
    entry_t h;
    rst = r; ce_i = c; pc_i = p; inst_i = i; flush_i = f; id_ready_i = rd;
    #1;
    full = (sb.size() == DEPTH);
    push = c && !full && !f;
    pop  = (sb.size() != 0) && rd && !f;
    if (pop && !r) begin
      check("pop_pc", {32'h0, id_pc_o}, {32'h0, sb[0].pc});
      check("pop_inst", {32'h0, id_inst_o}, {32'h0, sb[0].inst});
    end
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      m_ovf = 1'b0;
    end else if (f) begin
      sb.delete();
    end else begin
      if (c && full) m_ovf = 1'b1;
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back('{pc: p, inst: i});
    end
    h = (sb.size() != 0) ? sb[0] : '{pc: 32'h0, inst: 32'h0};
    check("count", {61'h0, count_o}, 64'(sb.size()));
    check("valid", {63'h0, id_valid_o}, {63'h0, sb.size() != 0});
    check("full", {63'h0, full_o}, {63'h0, sb.size() == DEPTH});
    check("head_pc", {32'h0, id_pc_o}, {32'h0, h.pc});
    check("head_inst", {32'h0, id_inst_o}, {32'h0, h.inst});
    check("ovf", {63'h0, ovf_o}, {63'h0, m_ovf});
  endtask

  vec_t vecs[8];

  initial begin
    // Fill then drain with decode stalled, then released.
    vecs[0] = '{1'b1, 32'h0, 32'hA0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0, 32'hA0};
    vecs[1] = '{1'b1, 32'h4, 32'hA1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0, 32'hA0};
    vecs[2] = '{1'b1, 32'h8, 32'hA2, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0, 32'hA0};
    vecs[3] = '{1'b1, 32'hC, 32'hA3, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 32'h0, 32'hA0};
    vecs[4] = '{1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 32'h4, 32'hA1};
    vecs[5] = '{1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 32'h8, 32'hA2};
    vecs[6] = '{1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 32'hC, 32'hA3};
    vecs[7] = '{1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0};

    // Reset held two cycles while a fetch is presented.
    step(1'b1, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset_count", {61'h0, count_o}, 64'h0);
    check("reset_pc", {32'h0, id_pc_o}, 64'h0);

    for (int k = 0; k < 8; k++) begin
      step(1'b0, vecs[k].ce, vecs[k].pc, vecs[k].inst, vecs[k].flush, vecs[k].ready);
      check($sformatf("vec%0d_cnt", k), {61'h0, count_o}, {61'h0, vecs[k].cnt});
      check($sformatf("vec%0d_valid", k), {63'h0, id_valid_o}, {63'h0, vecs[k].valid});
      check($sformatf("vec%0d_full", k), {63'h0, full_o}, {63'h0, vecs[k].full});
      check($sformatf("vec%0d_pc", k), {32'h0, id_pc_o}, {32'h0, vecs[k].hpc});
      check($sformatf("vec%0d_inst", k), {32'h0, id_inst_o}, {32'h0, vecs[k].hinst});
    end

    // Streaming through the pointer wrap: occupancy settles at one.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 32'(k * 4), 32'h100 + 32'(k), 1'b0, 1'b1);
      check($sformatf("stream%0d_cnt", k), {61'h0, count_o}, 64'h1);
      check($sformatf("stream%0d_pc", k), {32'h0, id_pc_o}, 64'(k * 4));
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("stream_drained", {63'h0, id_valid_o}, 64'h0);

    // Full collision: rejected fetch, pop still happens, sticky overflow.
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'(k * 4), 32'hB0 + 32'(k), 1'b0, 1'b0);
    check("coll_full", {63'h0, full_o}, 64'h1);
    step(1'b0, 1'b1, 32'h10, 32'hBF, 1'b0, 1'b1);
    check("coll_count", {61'h0, count_o}, 64'h3);
    check("coll_head", {32'h0, id_pc_o}, 64'h4);
    check("coll_ovf", {63'h0, ovf_o}, 64'h1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ovf_sticky", {63'h0, ovf_o}, 64'h1);

    // Flush with a fetch and a pop in the same cycle: both ignored.
    step(1'b0, 1'b1, 32'h80, 32'hC0, 1'b1, 1'b1);
    check("flush_count", {61'h0, count_o}, 64'h0);
    check("flush_valid", {63'h0, id_valid_o}, 64'h0);
    step(1'b0, 1'b1, 32'h100, 32'hC1, 1'b0, 1'b0);
    check("post_flush_pc", {32'h0, id_pc_o}, 64'h100);
    check("post_flush_ovf", {63'h0, ovf_o}, 64'h1);

    // Reset mid-operation clears everything including overflow.
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("midrst_ovf", {63'h0, ovf_o}, 64'h0);
    check("midrst_count", {61'h0, count_o}, 64'h0);

    // Decode ready while empty moves nothing.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("empty_ready_count", {61'h0, count_o}, 64'h0);
    step(1'b0, 1'b1, 32'h200, 32'hD0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h204, 32'hD1, 1'b0, 1'b0);
    check("empty_ready_head", {32'h0, id_pc_o}, 64'h200);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("empty_ready_next", {32'h0, id_pc_o}, 64'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC/instruction-memory stage and the decode (ID) stage of the openMIPS pipeline. It captures each fetched {pc, inst} pair while the PC stage's chip enable is high, buffers up to DEPTH pairs, and presents the oldest pair to decode in show-ahead fashion. It back-pressures the PC stage when full and discards all buffered instructions on a branch/exception flush.

## Interface

- DEPTH, 4: queue entries; power of two, ≥2.
- AW, 32: instruction address width (InstAddrBus).
- DW, 32: instruction word width (InstBus).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce_i  in  1  PC-stage chip enable; high = pc_i/inst_i hold a valid fetched pair this cycle.
- pc_i  in  AW  address of fetched instruction.
- inst_i  in  DW  fetched instruction word.
- flush_i  in  1  discard all queued entries (branch taken / exception).
- id_ready_i  in  1  decode accepts head entry this cycle.
- full_o  out  1  queue full; PC stage must stall (hold pc, keep ce).
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  AW  head entry address; 0 when empty.
- id_inst_o  out  DW  head entry instruction; 0 when empty.
- count_o  out  log2(DEPTH)+1  occupied entries, 0..DEPTH.
- ovf_o  out  1  sticky protocol-violation flag.

## Operation

- Storage: DEPTH-entry circular buffer of {pc, inst}; write pointer wp, read pointer rp, each log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter cnt.
- push = ce_i & ~full_o & ~flush_i. Writes {pc_i, inst_i} at wp; wp+1.
- pop = id_valid_o & id_ready_i & ~flush_i. rp+1.
- cnt next = cnt + push − pop; simultaneous push and pop leave cnt unchanged.
- full_o = (cnt == DEPTH); id_valid_o = (cnt != 0); both decoded from registered cnt, no combinational path from inputs.
- id_pc_o/id_inst_o = entry at rp when id_valid_o, else all zeros (ZeroWord).
- No bypass: a pair pushed while empty is not visible on the same cycle.
- Flush: next cycle cnt=0, wp=rp=0; push and pop in the flush cycle are ignored; storage contents need not be cleared.
- Full and ce_i high: pair not written; ovf_o set (PC stage must have stalled). Pop in same cycle still happens; full_o falls next cycle, the rejected pair must be re-presented by the PC stage.
- ovf_o: set on ce_i & full_o & ~flush_i; cleared only by rst.
- id_ready_i while empty: no effect.

## Timing

- Reset (rst high at edge): cnt=0, wp=rp=0, ovf_o=0; therefore full_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0. rst overrides flush_i, ce_i, id_ready_i.
- Reset mid-operation: all entries lost, same as reset values, one edge.
- Latency push→head: 1 cycle when empty (id_valid_o rises cycle after push).
- Pop→next head: 1 cycle; back-to-back push/pop sustains 1 instruction/cycle at any occupancy 1..DEPTH−1.
- full_o asserts the cycle after the DEPTH-th push; deasserts the cycle after first pop.
- Flush: id_valid_o low the cycle after flush_i high; a push in the following cycle is accepted normally.
- Pointer wrap: DEPTH−1 → 0 with no bubble.

## Test plan

- Reset: hold rst 2 cycles with ce_i=1, pc_i=0x40 -> all outputs 0, count_o=0, ovf_o=0 after release.
- Fill/drain: id_ready_i=0, push pc 0x0,0x4,0x8,0xC with inst 0xA0..0xA3 -> full_o=1 after 4th edge, count_o=4; then id_ready_i=1 -> id_pc_o 0x0,0x4,0x8,0xC in order on consecutive cycles, then id_valid_o=0, id_pc_o=0.
- Streaming with wrap: ce_i=1 and id_ready_i=1 for 10 cycles, pc 0x0..0x24 -> count_o stays 1 after first cycle, every pc appears exactly once, one cycle after its push.
- Full collision: queue full, ce_i=1 pc=0x10, id_ready_i=1 -> 0x10 not stored, head 0x0 popped, count_o=3, ovf_o=1 and remains 1 until rst.
- Flush: count_o=3, assert flush_i with ce_i=1 pc=0x80 and id_ready_i=1 -> next cycle count_o=0, id_valid_o=0; push pc=0x100 next -> id_pc_o=0x100 one cycle later.
- Empty ready: id_ready_i=1, ce_i=0 for 5 cycles from reset -> count_o=0, no pointer movement (subsequent push appears correctly).
